// File: rtl/count_monitor.sv
// Sequence monitor for a free-running up-counter: tracks lock, counts wraps and
// errors, and queues ACQ/ERR/LOSS event records into a small FWFT FIFO.
module count_monitor #(
    parameter int WIDTH      = 8,
    parameter int LOSS_LIMIT = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_count,
    input  logic             in_en,
    input  logic             clr,
    output logic             locked,
    output logic [15:0]      wraps,
    output logic [15:0]      errors,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [WIDTH+1:0] ev_data,
    output logic             ev_overflow
);

    // state  | meaning
    // SYNC   | waiting for first sample after reset or clr
    // TRACK  | locked, every sample checked against expected
    // LOST   | lock dropped, waiting for one matching sample
    typedef enum logic [1:0] {ST_SYNC, ST_TRACK, ST_LOST} state_t;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = WIDTH + 2;
    localparam logic [WIDTH-1:0] ONE      = 1;
    localparam logic [3:0]       LIMIT    = 4'(LOSS_LIMIT);
    localparam logic [AW:0]      DEPTH_CT = (AW+1)'(FIFO_DEPTH);
    localparam logic [1:0]       T_ACQ    = 2'b01;
    localparam logic [1:0]       T_ERR    = 2'b10;
    localparam logic [1:0]       T_LOSS   = 2'b11;

    state_t            state, state_n;
    logic [WIDTH-1:0]  expected, expected_n;
    logic [3:0]        miss, miss_n, miss_inc;
    logic [15:0]       wraps_n, errors_n;
    logic              push;
    logic [EW-1:0]     push_data;

    logic [EW-1:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic [AW:0]       fill;
    logic              pop, full, push_ok, drop;

    always_comb begin
        state_n    = state;
        expected_n = expected;
        miss_n     = miss;
        wraps_n    = wraps;
        errors_n   = errors;
        push       = 1'b0;
        push_data  = '0;
        miss_inc   = miss + 4'd1;
        if (in_en) begin
            case (state)
                ST_SYNC: begin
                    expected_n = in_count + ONE;
                    push       = 1'b1;
                    push_data  = {T_ACQ, in_count};
                    state_n    = ST_TRACK;
                end
                ST_TRACK: begin
                    expected_n = in_count + ONE;
                    if (in_count == expected) begin
                        miss_n = '0;
                        if (in_count == '0) wraps_n = wraps + 16'd1;
                    end else begin
                        if (errors != 16'hFFFF) errors_n = errors + 16'd1;
                        push = 1'b1;
                        if (miss_inc == LIMIT) begin
                            push_data = {T_LOSS, in_count};
                            state_n   = ST_LOST;
                            miss_n    = '0;
                        end else begin
                            push_data = {T_ERR, in_count};
                            miss_n    = miss_inc;
                        end
                    end
                end
                ST_LOST: begin
                    expected_n = in_count + ONE;
                    if (in_count == expected) begin
                        push      = 1'b1;
                        push_data = {T_ACQ, in_count};
                        state_n   = ST_TRACK;
                    end
                end
                default: state_n = ST_SYNC;
            endcase
        end
    end

    assign ev_valid = (fill != '0);
    assign ev_data  = ev_valid ? mem[rd_ptr] : '0;
    assign locked   = (state == ST_TRACK);
    assign pop      = ev_valid & ev_ready;
    assign full     = (fill == DEPTH_CT);
    assign push_ok  = push & (~full | pop);
    assign drop     = push & full & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_SYNC;
            expected    <= '0;
            miss        <= '0;
            wraps       <= '0;
            errors      <= '0;
            ev_overflow <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fill        <= '0;
        end else if (clr) begin
            state       <= ST_SYNC;
            miss        <= '0;
            wraps       <= '0;
            errors      <= '0;
            ev_overflow <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fill        <= '0;
        end else begin
            state    <= state_n;
            expected <= expected_n;
            miss     <= miss_n;
            wraps    <= wraps_n;
            errors   <= errors_n;
            if (drop) ev_overflow <= 1'b1;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

    // Storage needs no reset: ev_data is gated by ev_valid.
    always_ff @(posedge clk) begin
        if (push_ok && !clr) mem[wr_ptr] <= push_data;
    end

endmodule
